// File: rtl/eth_header_tx_arbiter.sv
// ---------------------------------------------------------------------------
// packet_defs: header types shared by requesters and the TX arbiter.
// ---------------------------------------------------------------------------
package packet_defs;

  // Compact 2-bit protocol code carried by each requester; 2'b11 is illegal.
  typedef enum logic [1:0] {
    ETH_IPV4 = 2'b00,
    ETH_ARP  = 2'b01,
    ETH_IPV6 = 2'b10,
    ETH_RSVD = 2'b11
  } ethertype_e;

  typedef struct packed {
    logic [47:0] dest;
    logic [47:0] src;
    ethertype_e  ethertype;
  } packet_header_t;

endpackage

// ---------------------------------------------------------------------------
// eth_header_tx_arbiter
//   Round-robin arbiter that accepts one requester header at a time and
//   serialises it as 14 bytes (dest MAC, source MAC, EtherType) on a
//   valid/ready byte stream toward the MAC transmit path.
//
// Ports
//   clk, rst         clock, synchronous active-high reset
//   req_valid[i]     requester i has a header pending
//   req_hdr[i]       header of requester i (stable until accepted)
//   req_ready[i]     one-hot acceptance strobe (combinational, IDLE only)
//   out_valid/data   header byte stream, out_first on byte 0,
//   out_first/last   out_last on byte 13
//   out_ready        downstream byte acceptance
//   grant_id         requester currently (or most recently) sent
//   busy             high while serialising
//   err_ethertype    one-cycle pulse after accepting an illegal EtherType
// ---------------------------------------------------------------------------
module eth_header_tx_arbiter #(
  parameter int N_REQ = 4
) (
  input  logic                                  clk,
  input  logic                                  rst,
  input  logic [N_REQ-1:0]                      req_valid,
  input  packet_defs::packet_header_t [N_REQ-1:0] req_hdr,
  output logic [N_REQ-1:0]                      req_ready,
  output logic                                  out_valid,
  output logic [7:0]                            out_data,
  output logic                                  out_first,
  output logic                                  out_last,
  input  logic                                  out_ready,
  output logic [$clog2(N_REQ)-1:0]              grant_id,
  output logic                                  busy,
  output logic                                  err_ethertype
);

  import packet_defs::*;

  localparam int GW = $clog2(N_REQ);
  localparam logic [3:0] LAST_IDX = 4'd13;

  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } state_e;

  // Map the 2-bit protocol code to the on-wire EtherType value.
  function automatic logic [15:0] etype_map(input ethertype_e et);
    logic [15:0] v;
    case (et)
      ETH_IPV4: v = 16'h0800;
      ETH_ARP:  v = 16'h0806;
      ETH_IPV6: v = 16'h86DD;
      default:  v = 16'h0000;
    endcase
    return v;
  endfunction

  // Byte i of the flattened 112-bit header, byte 0 being the MSB.
  function automatic logic [7:0] hdr_byte(input logic [111:0] v, input logic [3:0] i);
    logic [7:0] b;
    b = 8'h00;
    for (int k = 0; k < 14; k++) begin
      if (i == 4'(k)) b = v[8*(13-k) +: 8];
    end
    return b;
  endfunction

  // Round-robin pick: first set bit above 'last', otherwise first set bit
  // at or below it (wrap-around).
  function automatic logic [GW-1:0] rr_pick(input logic [N_REQ-1:0] v, input logic [GW-1:0] last);
    logic          found;
    logic [GW-1:0] pick;
    found = 1'b0;
    pick  = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (!found && v[i] && (i > int'(last))) begin
        found = 1'b1;
        pick  = GW'(i);
      end
    end
    for (int i = 0; i < N_REQ; i++) begin
      if (!found && v[i] && (i <= int'(last))) begin
        found = 1'b1;
        pick  = GW'(i);
      end
    end
    return pick;
  endfunction

  // State
  state_e         state_q,     state_d;
  logic [3:0]     idx_q,       idx_d;
  logic [111:0]   hdr_q,       hdr_d;
  logic [GW-1:0]  grant_q,     grant_d;
  logic [GW-1:0]  last_q,      last_d;
  logic           busy_q,      busy_d;
  logic           err_q,       err_d;
  logic           out_valid_q, out_valid_d;
  logic [7:0]     out_data_q,  out_data_d;
  logic           out_first_q, out_first_d;
  logic           out_last_q,  out_last_d;

  // Arbitration
  logic           any_req;
  logic           accept;
  logic [GW-1:0]  win_idx;
  packet_header_t sel_hdr;
  logic [111:0]   sel_flat;

  always_comb begin
    any_req  = |req_valid;
    win_idx  = rr_pick(req_valid, last_q);
    sel_hdr  = req_hdr[win_idx];
    sel_flat = {sel_hdr.dest, sel_hdr.src, etype_map(sel_hdr.ethertype)};
    // Acceptance is only possible in IDLE and never while reset is held.
    accept    = (state_q == IDLE) && any_req && !rst;
    req_ready = accept ? (N_REQ'(1) << win_idx) : '0;
  end

  // Next-state logic
  // NOTE: every signal assigned in always_comb gets a default on entry;
  // a path that leaves one unassigned would infer a latch.
  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    hdr_d       = hdr_q;
    grant_d     = grant_q;
    last_d      = last_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_first_d = out_first_q;
    out_last_d  = out_last_q;
    err_d       = 1'b0;

    case (state_q)
      IDLE: begin
        if (any_req) begin
          hdr_d       = sel_flat;
          idx_d       = 4'd0;
          grant_d     = win_idx;
          last_d      = win_idx;
          state_d     = SEND;
          out_valid_d = 1'b1;
          out_data_d  = sel_flat[111:104];
          out_first_d = 1'b1;
          out_last_d  = 1'b0;
          err_d       = (sel_hdr.ethertype == ETH_RSVD);
        end
      end
      SEND: begin
        // Without a handshake everything simply holds (backpressure).
        if (out_ready) begin
          if (idx_q == LAST_IDX) begin
            state_d     = IDLE;
            out_valid_d = 1'b0;
            out_data_d  = 8'h00;
            out_first_d = 1'b0;
            out_last_d  = 1'b0;
          end else begin
            idx_d       = idx_q + 4'd1;
            out_data_d  = hdr_byte(hdr_q, idx_d);
            out_first_d = 1'b0;
            out_last_d  = (idx_d == LAST_IDX);
          end
        end
      end
      default: state_d = IDLE;
    endcase

    busy_d = (state_d == SEND);
  end

  // NOTE: sequential state is updated only with non-blocking assignments so
  // every flop samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      idx_q       <= 4'd0;
      hdr_q       <= '0;
      grant_q     <= '0;
      last_q      <= GW'(N_REQ - 1);
      busy_q      <= 1'b0;
      err_q       <= 1'b0;
      out_valid_q <= 1'b0;
      out_data_q  <= 8'h00;
      out_first_q <= 1'b0;
      out_last_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      hdr_q       <= hdr_d;
      grant_q     <= grant_d;
      last_q      <= last_d;
      busy_q      <= busy_d;
      err_q       <= err_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_first_q <= out_first_d;
      out_last_q  <= out_last_d;
    end
  end

  assign out_valid     = out_valid_q;
  assign out_data      = out_data_q;
  assign out_first     = out_first_q;
  assign out_last      = out_last_q;
  assign grant_id      = grant_q;
  assign busy          = busy_q;
  assign err_ethertype = err_q;

endmodule

// File: doc/eth_header_tx_arbiter.md
# eth_header_tx_arbiter

- Round-robin arbiter and serializer for Ethernet headers.
- Up to N_REQ requesters each present a `packet_defs::packet_header_t`.
- The block grants one requester at a time, latches its header, and streams it as 14 bytes (dest MAC, source MAC, 2-byte EtherType) on a valid/ready byte interface toward the MAC transmit path.

## Interface

Parameters:
- N_REQ, 4, number of requesters (2..8)

Ports:
- Clocking: one clock; reset is synchronous and active-high.
- clk  in  1  sole clock; all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- req_valid  in  N_REQ  requester i has a header pending
- req_hdr  in  N_REQ x packet_header_t  header per requester; must be stable while req_valid[i] && !req_ready[i]
- req_ready  out  N_REQ  one-hot acceptance strobe; header i captured at this edge
- out_valid  out  1  out_data holds a valid header byte
- out_data  out  8  header byte
- out_first  out  1  marks byte 0 (dest[47:40])
- out_last  out  1  marks byte 13 (EtherType low byte)
- out_ready  in  1  downstream accepts byte when out_valid && out_ready
- grant_id  out  $clog2(N_REQ)  index of the requester currently being sent
- busy  out  1  high in SEND state
- err_ethertype  out  1  one-cycle pulse: accepted header had the illegal ethertype encoding 2'b11

## Operation

- FSM has two states, IDLE and SEND. Reset state is IDLE.
- Round-robin pointer `last` resets to N_REQ-1, so requester 0 has first priority after reset.
- **IDLE:**
  - If any req_valid is set, the winner is the first set bit searching from last+1 upward, with wrap-around.
  - req_ready[winner] = 1 combinationally in that cycle. It is forced to 0 while rst=1 and in SEND.
  - At the clock edge: header latched, grant_id <= winner, last <= winner, byte index <= 0, state <= SEND.
  - If no req_valid is set, stay in IDLE and req_ready = 0.
- **SEND:**
  - out_valid = 1 and out_data = byte[idx].
  - On out_valid && out_ready, idx increments.
  - On the handshake at idx = 13, the FSM returns to IDLE.
- **Byte order:**
  - idx 0..5: dest[47:40] .. dest[7:0]
  - idx 6..11: source[47:40] .. source[7:0]
  - idx 12..13: EtherType high byte, then low byte
- **EtherType mapping:**
  - IPV4 -> 16'h0800
  - ARP -> 16'h0806
  - IPV6 -> 16'h86DD
  - 2'b11 -> 16'h0000, and err_ethertype pulses for the one cycle after acceptance. The header is still sent.
- out_first = (idx==0) && out_valid; out_last = (idx==13) && out_valid.
- A requester dropping req_valid after acceptance has no effect on the header in flight. A requester dropping req_valid before acceptance is never granted.
- Requests arriving during SEND wait; they are arbitrated in the next IDLE cycle.

## Timing

- **Reset values:** out_valid 0, out_data 8'h00, out_first 0, out_last 0, grant_id 0, busy 0, err_ethertype 0, req_ready 0.
- **Acceptance to first byte:** acceptance at edge T makes out_valid=1 with byte 0 in cycle T+1. This is 1 cycle of latency.
- **Throughput:**
  - With out_ready held at 1, one header takes 14 SEND cycles plus 1 IDLE arbitration cycle, i.e. 15 cycles per header.
  - The earliest next acceptance is the IDLE cycle after out_last is accepted.
- **Backpressure:** while out_valid && !out_ready, out_data, out_first, out_last, grant_id and idx hold unchanged.
- busy = (state == SEND), registered.
- **Reset mid-SEND:** all outputs go to their reset values at the next edge. The partial header is abandoned and out_last is not issued. The pointer returns to N_REQ-1.
- **Simultaneous requests:** exactly one req_ready bit is ever set per cycle.

## Test plan

- **Single request:**
  - Stimulus: after reset, req_valid=4'b0001; hdr0 = dest 48'h0011_2233_4455, src 48'hAABB_CCDD_EEFF, IPV4; out_ready=1.
  - Required response: req_ready=4'b0001 for one cycle; bytes 00 11 22 33 44 55 AA BB CC DD EE FF 08 00; out_first on byte 0, out_last on byte 13; grant_id=0.
- **Round-robin fairness:**
  - Stimulus: req_valid=4'b1111 held continuously.
  - Required response: grant order 0,1,2,3,0; each grant 15 cycles apart.
- **Wrap and skip:**
  - Stimulus: last grant=2, req_valid=4'b0011.
  - Required response: next grant is 0, then 1.
- **Backpressure:**
  - Stimulus: out_ready=0 for 5 cycles at idx 7.
  - Required response: out_data holds src[39:32] and out_valid stays 1; the sequence resumes intact when out_ready=1.
- **Illegal EtherType:**
  - Stimulus: header with ethertype 2'b11.
  - Required response: err_ethertype=1 for exactly one cycle after acceptance; bytes 12..13 are 00 00.
- **Reset mid-packet:**
  - Stimulus: assert rst for one cycle at idx 4.
  - Required response: next cycle out_valid=0, busy=0, grant_id=0, and no out_last. With req_valid=4'b1001 after reset, requester 0 is granted first.
